// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, ALU/mux encodings and FSM types
// shared by the multi-cycle RV32I control unit.
package multicycle_control_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
      ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE,
      ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
   } alu_op_e;

   typedef enum logic [2:0] {
      RES_ALU, RES_IMM, RES_PC_IMM, RES_PC4, RES_LOAD
   } result_src_e;

   typedef enum logic [1:0] {
      PC_JALR, PC_JAL, PC_BRANCH, PC_PLUS4
   } pc_src_e;

   typedef enum logic [2:0] {
      IT_U, IT_J, IT_R, IT_I, IT_S, IT_B
   } instr_type_e;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
      S_MEM, S_WRITEBACK, S_TRAP
   } state_e;

   typedef enum logic [1:0] {
      TC_NONE, TC_ILLEGAL, TC_TIMEOUT
   } trap_cause_e;

   typedef struct packed {
      alu_op_e     alu;
      logic        alu_src;
      result_src_e res;
      instr_type_e itype;
      logic        illegal;
   } dec_t;

   function automatic int wd_width(int t);
      return (t < 1) ? 1 : $clog2(t + 1);
   endfunction

   function automatic alu_op_e alu_arith(logic [2:0] f3, logic alt);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: shared fetch/data memory port with a
// valid/ready handshake.
interface multicycle_control_if;
   logic       mem_req;
   logic       mem_we;
   logic [2:0] mem_funct3;
   logic       adr_src;
   logic       mem_ready;

   modport master (
      output mem_req, mem_we, mem_funct3, adr_src,
      input  mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_funct3, adr_src,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_control_instr_decode.sv
// instr_decode: combinational RV32I field decode into ALU op,
// operand/result selects, immediate format and an illegal flag.
module instr_decode
   import multicycle_control_pkg::*;
(
   input  logic [31:0] instr_i,
   output dec_t        dec_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic       f7_5;
   logic       unused_fields;

   assign opc  = instr_i[6:0];
   assign f3   = instr_i[14:12];
   assign f7_5 = instr_i[30];
   assign unused_fields = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

   always_comb begin
      dec_o.alu     = ALU_ADD;
      dec_o.alu_src = 1'b1;
      dec_o.res     = RES_ALU;
      dec_o.itype   = IT_I;
      dec_o.illegal = 1'b0;
      unique case (opc)
         OP_REG: begin
            dec_o.alu     = alu_arith(f3, f7_5);
            dec_o.alu_src = 1'b0;
            dec_o.itype   = IT_R;
            dec_o.illegal = f7_5 && (f3 != F3_ADD) && (f3 != F3_SR);
         end
         OP_IMM: begin
            // funct7_5 only selects SRAI; on ADDI it is immediate data
            dec_o.alu     = alu_arith(f3, f7_5 && (f3 == F3_SR));
            dec_o.illegal = f7_5 && (f3 == F3_SLL);
         end
         OP_LOAD: begin
            dec_o.res     = RES_LOAD;
            dec_o.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OP_STORE: begin
            dec_o.itype   = IT_S;
            dec_o.illegal = f3 > 3'b010;
         end
         OP_BRANCH: begin
            dec_o.alu_src = 1'b0;
            dec_o.itype   = IT_B;
            unique case (f3)
               F3_BEQ:  dec_o.alu = ALU_BEQ;
               F3_BNE:  dec_o.alu = ALU_BNE;
               F3_BLT:  dec_o.alu = ALU_BLT;
               F3_BGE:  dec_o.alu = ALU_BGE;
               F3_BLTU: dec_o.alu = ALU_BLTU;
               F3_BGEU: dec_o.alu = ALU_BGEU;
               default: dec_o.illegal = 1'b1;
            endcase
         end
         OP_LUI: begin
            dec_o.res   = RES_IMM;
            dec_o.itype = IT_U;
         end
         OP_AUIPC: begin
            dec_o.res   = RES_PC_IMM;
            dec_o.itype = IT_U;
         end
         OP_JAL: begin
            dec_o.res   = RES_PC4;
            dec_o.itype = IT_J;
         end
         OP_JALR: begin
            dec_o.res = RES_PC4;
         end
         default: begin
            dec_o.alu_src = 1'b0;
            dec_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM, shared memory port control and
// bus-timeout watchdog for the multi-cycle RV32I core.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter bit TRAP_EN        = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master mem,
   input  logic [31:0]          instr_i,
   input  logic                 branch_taken_i,
   output logic                 ir_we_o,
   output logic                 pc_we_o,
   output logic [1:0]           pc_src_o,
   output logic                 reg_we_o,
   output logic                 alu_src_o,
   output logic [3:0]           alu_control_o,
   output logic [2:0]           result_src_o,
   output logic [2:0]           instruction_type_o,
   output logic                 retire_o,
   output logic                 trap_o,
   output logic [1:0]           trap_cause_o
);

   localparam int WDW = wd_width(TIMEOUT_CYCLES);
   localparam bit WD_ON = TIMEOUT_CYCLES > 0;
   localparam logic [WDW-1:0] WD_LAST =
      WDW'(WD_ON ? TIMEOUT_CYCLES - 1 : 0);

   state_e         state_q, state_d;
   trap_cause_e    cause_q, cause_d;
   logic [WDW-1:0] wd_q, wd_d;
   dec_t           dec;
   logic [6:0]     opc;
   logic [2:0]     f3;
   logic           is_load, is_store, is_branch;
   logic           is_jal, is_jalr;
   logic           req_c, wait_c, wd_expire, dec_vis;
   logic           unused_instr;

   instr_decode u_dec (
      .instr_i (instr_i),
      .dec_o   (dec)
   );

   assign opc       = instr_i[6:0];
   assign f3        = instr_i[14:12];
   assign is_load   = opc == OP_LOAD;
   assign is_store  = opc == OP_STORE;
   assign is_branch = opc == OP_BRANCH;
   assign is_jal    = opc == OP_JAL;
   assign is_jalr   = opc == OP_JALR;
   assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};

   assign req_c   = (state_q == S_FETCH) || (state_q == S_MEM);
   assign wait_c  = req_c && !mem.mem_ready;
   // a completing request never expires: ready beats the watchdog
   assign wd_expire = WD_ON && wait_c && (wd_q == WD_LAST);
   assign dec_vis = state_q inside {S_DECODE, S_EXECUTE,
                                    S_MEM, S_WRITEBACK};

   always_comb begin
      state_d            = state_q;
      cause_d            = cause_q;
      mem.mem_req        = req_c;
      mem.mem_we         = 1'b0;
      mem.mem_funct3     = 3'b000;
      mem.adr_src        = 1'b0;
      ir_we_o            = 1'b0;
      pc_we_o            = 1'b0;
      pc_src_o           = PC_JALR;
      reg_we_o           = 1'b0;
      alu_src_o          = 1'b0;
      alu_control_o      = ALU_ADD;
      result_src_o       = RES_ALU;
      instruction_type_o = IT_U;
      if (dec_vis) begin
         alu_src_o          = dec.alu_src;
         alu_control_o      = dec.alu;
         result_src_o       = dec.res;
         instruction_type_o = dec.itype;
      end
      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (mem.mem_ready) begin
               ir_we_o = 1'b1;
               state_d = S_DECODE;
            end else if (wd_expire) begin
               state_d = S_TRAP;
               cause_d = TC_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (!dec.illegal) begin
               state_d = S_EXECUTE;
            end else if (TRAP_EN) begin
               state_d = S_TRAP;
               cause_d = TC_ILLEGAL;
            end else begin
               pc_we_o  = 1'b1;
               pc_src_o = PC_PLUS4;
               state_d  = S_FETCH;
            end
         end
         S_EXECUTE: begin
            if (is_branch) begin
               pc_we_o  = 1'b1;
               pc_src_o = branch_taken_i ? PC_BRANCH : PC_PLUS4;
               state_d  = S_FETCH;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEM: begin
            mem.adr_src    = 1'b1;
            mem.mem_we     = is_store;
            mem.mem_funct3 = f3;
            if (mem.mem_ready) begin
               if (is_store) begin
                  pc_we_o  = 1'b1;
                  pc_src_o = PC_PLUS4;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end else if (wd_expire) begin
               state_d = S_TRAP;
               cause_d = TC_TIMEOUT;
            end
         end
         S_WRITEBACK: begin
            reg_we_o = 1'b1;
            pc_we_o  = 1'b1;
            pc_src_o = is_jal  ? PC_JAL  :
                       is_jalr ? PC_JALR : PC_PLUS4;
            state_d  = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wd_d = wd_q;
      if ((state_d != state_q) || mem.mem_ready) begin
         wd_d = '0;
      end else if (wait_c) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cause_q <= TC_NONE;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         wd_q    <= wd_d;
      end
   end

   assign retire_o     = pc_we_o;
   assign trap_o       = state_q == S_TRAP;
   assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream against a
// spec-level model via a scoreboard, plus directed trap/reset cases.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        illegal;
      logic [3:0]  alu;
      logic        alu_src;
      logic [2:0]  res;
      logic [2:0]  itype;
      logic [1:0]  pc_src;
      logic        reg_we;
      int          lat;
      logic        is_mem;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] ins;
   } exp_t;

   exp_t exp_q[$];
   localparam int N = 250;
   int   retired = 0;
   bit   run0 = 1'b0;

   // DUT0: illegal ops retire as NOPs; random stream
   logic        rst0_n, bt0;
   logic [31:0] instr0;
   logic        ir_we0, pc_we0, reg_we0, alu_src0, retire0, trap0;
   logic [1:0]  pc_src0, tc0;
   logic [3:0]  alu0;
   logic [2:0]  res0, it0;
   multicycle_control_if if0();

   multicycle_control #(.TIMEOUT_CYCLES(4), .TRAP_EN(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst0_n), .mem(if0),
      .instr_i(instr0), .branch_taken_i(bt0),
      .ir_we_o(ir_we0), .pc_we_o(pc_we0), .pc_src_o(pc_src0),
      .reg_we_o(reg_we0), .alu_src_o(alu_src0),
      .alu_control_o(alu0), .result_src_o(res0),
      .instruction_type_o(it0), .retire_o(retire0),
      .trap_o(trap0), .trap_cause_o(tc0)
   );

   // DUT1: trapping configuration for directed cases
   logic        rst1_n, bt1;
   logic [31:0] instr1;
   logic        ir_we1, pc_we1, reg_we1, alu_src1, retire1, trap1;
   logic [1:0]  pc_src1, tc1;
   logic [3:0]  alu1;
   logic [2:0]  res1, it1;
   multicycle_control_if if1();

   multicycle_control #(.TIMEOUT_CYCLES(4), .TRAP_EN(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst1_n), .mem(if1),
      .instr_i(instr1), .branch_taken_i(bt1),
      .ir_we_o(ir_we1), .pc_we_o(pc_we1), .pc_src_o(pc_src1),
      .reg_we_o(reg_we1), .alu_src_o(alu_src1),
      .alu_control_o(alu1), .result_src_o(res1),
      .instruction_type_o(it1), .retire_o(retire1),
      .trap_o(trap1), .trap_cause_o(tc1)
   );

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(logic [31:0] ins, logic bt,
                                  int fw, int mw);
      int   ar[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      int   br[8] = '{10, 11, -1, -1, 12, 13, 14, 15};
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic       s  = ins[30];
      exp_t e;
      e.ins = ins; e.illegal = 0; e.alu = 0; e.alu_src = 1;
      e.res = 0; e.itype = 3; e.pc_src = 2'b11; e.reg_we = 1;
      e.lat = 4 + fw; e.is_mem = 0; e.we = 0; e.f3 = f3;
      case (op)
         7'h33: begin
            e.itype = 2; e.alu_src = 0;
            e.illegal = s && f3 != 0 && f3 != 5;
            e.alu = 4'(ar[f3]);
            if (s && f3 == 0) e.alu = 1;
            if (s && f3 == 5) e.alu = 7;
         end
         7'h13: begin
            e.illegal = s && f3 == 1;
            e.alu = 4'(ar[f3]);
            if (s && f3 == 5) e.alu = 7;
         end
         7'h03: begin
            e.res = 4; e.lat = 5 + fw + mw; e.is_mem = 1;
            e.illegal = f3 == 3 || f3 == 6 || f3 == 7;
         end
         7'h23: begin
            e.itype = 4; e.reg_we = 0; e.lat = 4 + fw + mw;
            e.is_mem = 1; e.we = 1; e.illegal = f3 >= 3;
         end
         7'h63: begin
            e.itype = 5; e.alu_src = 0; e.reg_we = 0;
            e.lat = 3 + fw; e.pc_src = bt ? 2'b10 : 2'b11;
            e.illegal = br[f3] < 0;
            e.alu = 4'(br[f3]);
         end
         7'h37: begin e.itype = 0; e.res = 1; end
         7'h17: begin e.itype = 0; e.res = 2; end
         7'h6F: begin e.itype = 1; e.res = 3; e.pc_src = 2'b01; end
         7'h67: begin e.res = 3; e.pc_src = 2'b00; end
         default: e.illegal = 1;
      endcase
      if (e.illegal) begin
         e.reg_we = 0; e.pc_src = 2'b11;
         e.lat = 2 + fw; e.is_mem = 0;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen();
      logic [6:0] ops[11];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
              7'h17, 7'h6F, 7'h67, 7'h7F, 7'h73};
      return {1'b0, 1'($urandom_range(0, 3) == 0), 5'b0,
              5'($urandom), 5'($urandom), 3'($urandom),
              5'($urandom), ops[$urandom_range(0, 10)]};
   endfunction

   function automatic int pick_wait();
      return ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
   endfunction

   // memory responder and stimulus source for DUT0
   initial begin : drv0
      bit busy;
      int wl, mwc, fw;
      exp_t e;
      busy = 0; wl = 0; mwc = 0;
      if0.mem_ready = 1'b0; bt0 = 1'b0; instr0 = '0;
      forever begin
         @(negedge clk);
         if (!run0) begin
            if0.mem_ready = 1'b0;
            continue;
         end
         if (if0.mem_req && !busy) begin
            busy = 1;
            if (!if0.adr_src) begin
               instr0 = gen();
               bt0 = 1'($urandom);
               fw = pick_wait();
               mwc = pick_wait();
               e = model(instr0, bt0, fw, mwc);
               exp_q.push_back(e);
               wl = fw;
            end else begin
               wl = mwc;
            end
         end
         if (if0.mem_req) begin
            if (wl == 0) begin
               if0.mem_ready = 1'b1;
               busy = 0;
            end else begin
               if0.mem_ready = 1'b0;
               wl--;
            end
         end else begin
            if0.mem_ready = 1'b0;
         end
      end
   end

   // scoreboard monitor for DUT0
   initial begin : mon0
      int   cyc, last;
      exp_t e;
      wait (run0);
      cyc = 0; last = 0;
      while (1) begin
         @(negedge clk);
         #1;
         if (!run0) break;
         if (cyc == 0)
            chk("idle_outputs0",
                {if0.mem_req, if0.mem_we, if0.adr_src, ir_we0,
                 pc_we0, reg_we0, trap0, tc0}, 0);
         if (if0.mem_req && if0.adr_src) begin
            if (exp_q.size() == 0) begin
               chk("data_req_unexpected", 1, 0);
            end else begin
               e = exp_q[0];
               chk("data_req_legal", e.is_mem, 1);
               chk("mem_we", if0.mem_we, e.we);
               chk("mem_funct3", if0.mem_funct3, e.f3);
            end
         end
         if (pc_we0) begin
            if (exp_q.size() == 0) begin
               chk("retire_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pc_src", pc_src0, e.pc_src);
               chk("reg_we", reg_we0, e.reg_we);
               chk("retire", retire0, 1);
               chk("latency", cyc - last, e.lat);
               if (!e.illegal) begin
                  chk("alu_control", alu0, e.alu);
                  chk("alu_src", alu_src0, e.alu_src);
                  chk("instr_type", it0, e.itype);
               end
               if (e.reg_we) chk("result_src", res0, e.res);
               if (errors > 0 && errors < 4)
                  $display("  instr %08h", e.ins);
            end
            last = cyc;
            retired++;
         end
         cyc++;
      end
   end

   task automatic reset1();
      rst1_n = 1'b0;
      if1.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst1_n = 1'b1;
   endtask

   initial begin : main
      int n, nm, seen, wb_i, last_m, npc;
      bit bad;
      rst0_n = 1'b0; rst1_n = 1'b0;
      if1.mem_ready = 1'b0; bt1 = 1'b0; instr1 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {if1.mem_req, if1.mem_we, if1.mem_funct3, if1.adr_src,
           ir_we1, pc_we1, pc_src1, reg_we1, alu_src1, alu1, res1,
           it1, retire1, trap1, tc1}, 0);

      // random stream
      rst0_n = 1'b1;
      run0 = 1'b1;
      for (int i = 0; i < 8000 && retired < N; i++) @(posedge clk);
      chk("stream_complete", retired >= N, 1);
      run0 = 1'b0;
      chk("queue_drained", exp_q.size(), 0);
      chk("no_trap0", trap0, 0);

      // watchdog: ready stuck low in FETCH
      instr1 = 32'h002081B3;
      reset1();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (trap1) break;
         if (if1.mem_req) n++;
      end
      chk("timeout_wait_cycles", n, 4);
      chk("timeout_trap", trap1, 1);
      chk("timeout_cause", tc1, 2);
      chk("timeout_req_drop", if1.mem_req, 0);

      // ready on the last allowed cycle, then add retires
      reset1();
      n = 0; seen = 0; npc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if1.mem_req) begin
            n++;
            if1.mem_ready = (n >= 4);
         end else begin
            if1.mem_ready = 1'b0;
         end
         #1;
         if (ir_we1 && seen == 0) seen = n;
         if (pc_we1 && reg_we1 && pc_src1 == 2'b11) npc++;
      end
      chk("late_ready_ir_we", seen, 4);
      chk("late_ready_no_trap", trap1, 0);
      chk("late_ready_add_retire", npc, 1);

      // lw with three MEM wait cycles
      instr1 = 32'h0000A183;
      reset1();
      nm = 0; bad = 0; wb_i = -1; last_m = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if1.mem_req && if1.adr_src) begin
            if1.mem_ready = (nm == 3);
            nm++;
            last_m = i;
            if (if1.mem_funct3 != 3'b010 || if1.mem_we) bad = 1;
         end else begin
            if1.mem_ready = if1.mem_req;
         end
         #1;
         if (reg_we1) begin
            wb_i = i;
            chk("lw_result_src", res1, 4);
            chk("lw_pc_we", pc_we1, 1);
            break;
         end
      end
      chk("lw_mem_cycles", nm, 4);
      chk("lw_mem_stable", bad, 0);
      chk("lw_wb_follows", wb_i - last_m, 1);

      // illegal opcode traps with no retire
      instr1 = 32'h0000007F;
      reset1();
      if1.mem_ready = 1'b1;
      npc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (pc_we1) npc++;
      end
      chk("illegal_trap", trap1, 1);
      chk("illegal_cause", tc1, 1);
      chk("illegal_no_pc_we", npc, 0);
      chk("illegal_no_req", if1.mem_req, 0);

      // async reset in the middle of a store
      instr1 = 32'h0020A023;
      reset1();
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if1.mem_ready = if1.mem_req && !if1.adr_src;
         #1;
         if (if1.mem_we) begin n = 1; break; end
      end
      chk("store_reached_mem", n, 1);
      #2 rst1_n = 1'b0;
      #1;
      chk("async_req_drop", {if1.mem_req, if1.mem_we}, 0);
      if1.mem_ready = 1'b0;
      @(posedge clk);
      #1 rst1_n = 1'b1;
      @(negedge clk); #1;
      chk("post_reset_idle", if1.mem_req, 0);
      @(negedge clk); #1;
      chk("post_reset_fetch", {if1.mem_req, if1.adr_src}, 2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
